// File: rtl/cpu_check_pkg.sv
// Shared types and width helpers for the CPU self-test checker.
package cpu_check_pkg;

    // Field widths of a stored checkpoint; the checker's PC_WIDTH and
    // DATA_WIDTH parameters default to these and must agree with them.
    localparam int CHECK_PC_WIDTH   = 8;
    localparam int CHECK_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PC,
        ST_SETTLE,
        ST_COMPARE,
        ST_FINISH
    } check_state_t;

    typedef struct packed {
        logic [CHECK_PC_WIDTH-1:0]   pc;
        logic [CHECK_DATA_WIDTH-1:0] expected;
    } check_entry_t;

    // Bits needed to address DEPTH entries (at least one bit).
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a count from 0 to DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed for a down-to-zero style counter reaching cycles-1.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/check_table.sv
// Checkpoint storage: synchronous write, combinational read.
module check_table
    import cpu_check_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int IW    = index_width(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  check_entry_t  wr_data,
    input  logic [IW-1:0] rd_addr,
    output check_entry_t  rd_data
);

    check_entry_t mem [DEPTH];

    // Write one checkpoint when the controller accepts a load.
    // NOTE: the array has no reset; the controller's entry_count marks which
    // entries are valid, so clearing that count empties the table logically.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_selftest_checker.sv
// On-chip self-test checker: matches the core PC against a table of
// checkpoints and compares the observed register after a settle delay.
module cpu_selftest_checker
    import cpu_check_pkg::*;
#(
    parameter  int DATA_WIDTH     = CHECK_DATA_WIDTH,
    parameter  int PC_WIDTH       = CHECK_PC_WIDTH,
    parameter  int DEPTH          = 32,
    parameter  int SETTLE_CYCLES  = 2,
    parameter  int TIMEOUT_CYCLES = 1024,
    parameter  int STOP_ON_FAIL   = 1,
    localparam int IW             = index_width(DEPTH),
    localparam int CW             = count_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [PC_WIDTH-1:0]   load_pc,
    input  logic [DATA_WIDTH-1:0] load_expected,
    output logic                  load_ready,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [IW-1:0]         fail_index,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output logic [CW-1:0]         checks_passed,
    output logic [CW-1:0]         entry_count
);

    localparam int TW = timer_width(TIMEOUT_CYCLES);
    localparam int SW = timer_width(SETTLE_CYCLES);

    check_state_t  state;
    logic [IW-1:0] idx;
    logic [TW-1:0] watchdog;
    logic [SW-1:0] settle_cnt;
    check_entry_t  cur_entry;
    check_entry_t  new_entry;

    logic accept;
    logic pc_match;
    logic data_match;
    logic last_entry;
    logic do_compare;
    logic wd_expired;

    assign load_ready = (state == ST_IDLE) && (entry_count < CW'(DEPTH));
    assign accept     = load_valid && load_ready;
    assign new_entry  = '{pc: load_pc, expected: load_expected};

    check_table #(.DEPTH(DEPTH)) u_table (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr (entry_count[IW-1:0]),
        .wr_data (new_entry),
        .rd_addr (idx),
        .rd_data (cur_entry)
    );

    assign pc_match   = (pc_in == cur_entry.pc);
    assign data_match = (reg_data == cur_entry.expected);
    assign last_entry = (CW'(idx) == entry_count - CW'(1));
    assign wd_expired = (watchdog == TW'(TIMEOUT_CYCLES - 1));
    // With no settle delay the sample is taken on the matching edge itself.
    assign do_compare = (state == ST_COMPARE) ||
                        ((state == ST_WAIT_PC) && pc_match && (SETTLE_CYCLES == 0));

    // Run controller: table loading, PC tracking, watchdog and result capture.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; later assignments to state override earlier ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            watchdog      <= '0;
            settle_cnt    <= '0;
            entry_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            fail_index    <= '0;
            fail_actual   <= '0;
            checks_passed <= '0;
        end else begin
            if (accept) begin
                entry_count <= entry_count + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        timeout       <= 1'b0;
                        fail_index    <= '0;
                        fail_actual   <= '0;
                        checks_passed <= '0;
                        idx           <= '0;
                        watchdog      <= '0;
                        busy          <= 1'b1;
                        state         <= (entry_count == '0) ? ST_FINISH : ST_WAIT_PC;
                    end
                end
                ST_WAIT_PC: begin
                    if (pc_match) begin
                        settle_cnt <= '0;
                        if (SETTLE_CYCLES == 1) begin
                            state <= ST_COMPARE;
                        end else if (SETTLE_CYCLES > 1) begin
                            state <= ST_SETTLE;
                        end
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        state   <= ST_FINISH;
                    end else begin
                        watchdog <= watchdog + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 2)) begin
                        state <= ST_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_COMPARE: begin
                    // Outcome handled by the shared compare logic below.
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    pass  <= !fail && !timeout;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (do_compare) begin
                if (data_match) begin
                    checks_passed <= checks_passed + CW'(1);
                end else begin
                    if (!fail) begin
                        fail_index  <= idx;
                        fail_actual <= reg_data;
                    end
                    fail <= 1'b1;
                end
                if ((!data_match && (STOP_ON_FAIL != 0)) || last_entry) begin
                    state <= ST_FINISH;
                end else begin
                    idx      <= idx + IW'(1);
                    watchdog <= '0;
                    state    <= ST_WAIT_PC;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_selftest_checker.sv
// Self-checking bench: two checkers (stop-on-fail and continue-on-fail)
// driven by identical stimulus, checked against constants and a
// sequence-scanning reference model.
module tb_cpu_selftest_checker;

    localparam int DEPTH   = 8;
    localparam int SETTLE  = 2;
    localparam int TOUT    = 16;
    localparam int SEQ_LEN = 256;
    localparam int RUN_MAX = 240;

    typedef struct {
        int kd;
        int pass;
        int fail;
        int timeout;
        int fidx;
        int fact;
        int checks;
    } res_t;

    typedef struct {
        logic        lv;
        logic [7:0]  pc;
        logic [15:0] ex;
        logic        exp_ready;
        logic [3:0]  exp_count;
    } fill_vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [7:0]  load_pc;
    logic [15:0] load_expected;
    logic        start;
    logic [7:0]  pc_in;
    logic [15:0] reg_data;

    logic        load_ready_a, busy_a, done_a, pass_a, fail_a, timeout_a;
    logic [2:0]  fail_index_a;
    logic [15:0] fail_actual_a;
    logic [3:0]  checks_passed_a, entry_count_a;
    logic        load_ready_b, busy_b, done_b, pass_b, fail_b, timeout_b;
    logic [2:0]  fail_index_b;
    logic [15:0] fail_actual_b;
    logic [3:0]  checks_passed_b, entry_count_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  tab_pc  [DEPTH];
    logic [15:0] tab_exp [DEPTH];
    logic [7:0]  pc_seq  [SEQ_LEN];
    logic [15:0] reg_seq [SEQ_LEN];
    int kd_a, kd_b;

    always #5 clock = ~clock;

    cpu_selftest_checker #(
        .DATA_WIDTH(16), .PC_WIDTH(8), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TOUT), .STOP_ON_FAIL(1)
    ) dut_a (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_pc(load_pc),
        .load_expected(load_expected), .load_ready(load_ready_a), .start(start),
        .pc_in(pc_in), .reg_data(reg_data), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .timeout(timeout_a), .fail_index(fail_index_a),
        .fail_actual(fail_actual_a), .checks_passed(checks_passed_a),
        .entry_count(entry_count_a)
    );

    cpu_selftest_checker #(
        .DATA_WIDTH(16), .PC_WIDTH(8), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TOUT), .STOP_ON_FAIL(0)
    ) dut_b (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_pc(load_pc),
        .load_expected(load_expected), .load_ready(load_ready_b), .start(start),
        .pc_in(pc_in), .reg_data(reg_data), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .timeout(timeout_b), .fail_index(fail_index_b),
        .fail_actual(fail_actual_b), .checks_passed(checks_passed_b),
        .entry_count(entry_count_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; pc_in = '0; reg_data = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_entries(input int n);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1; load_pc = tab_pc[i]; load_expected = tab_exp[i];
            @(negedge clock);
        end
        load_valid = 1'b0;
    endtask

    task automatic clear_seq();
        for (int k = 0; k < SEQ_LEN; k++) begin
            pc_seq[k] = 8'd0; reg_seq[k] = 16'd0;
        end
    endtask

    // Pulse start, then present pc_seq/reg_seq one value per edge; record
    // the edge index (0 = first edge after the start edge) where done rises.
    task automatic run();
        kd_a = -1; kd_b = -1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < RUN_MAX; k++) begin
            pc_in = pc_seq[k]; reg_data = reg_seq[k];
            @(negedge clock);
            if (done_a && kd_a < 0) kd_a = k;
            if (done_b && kd_b < 0) kd_b = k;
            if (kd_a >= 0 && kd_b >= 0) break;
        end
        pc_in = '0; reg_data = '0;
    endtask

    // Reference: walk the entries in order, scanning the PC sequence for each
    // within the watchdog window and reading the register SETTLE values later.
    function automatic res_t model(input int n, input int stop);
        res_t r;
        int cursor, m, s;
        r = '{kd: 0, pass: 0, fail: 0, timeout: 0, fidx: 0, fact: 0, checks: 0};
        cursor = 0;
        for (int i = 0; i < n; i++) begin
            m = -1;
            for (int k = cursor; k < cursor + TOUT; k++) begin
                if (pc_seq[k] == tab_pc[i]) begin m = k; break; end
            end
            if (m < 0) begin
                r.timeout = 1; r.kd = cursor + TOUT; break;
            end
            s = m + SETTLE;
            r.kd = s + 1;
            cursor = s + 1;
            if (reg_seq[s] == tab_exp[i]) begin
                r.checks++;
            end else begin
                if (r.fail == 0) begin r.fidx = i; r.fact = int'(reg_seq[s]); end
                r.fail = 1;
                if (stop != 0) break;
            end
        end
        r.pass = (r.fail == 0 && r.timeout == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic res_t actual_a();
        return '{kd: kd_a, pass: int'(pass_a), fail: int'(fail_a), timeout: int'(timeout_a),
                 fidx: int'(fail_index_a), fact: int'(fail_actual_a), checks: int'(checks_passed_a)};
    endfunction

    function automatic res_t actual_b();
        return '{kd: kd_b, pass: int'(pass_b), fail: int'(fail_b), timeout: int'(timeout_b),
                 fidx: int'(fail_index_b), fact: int'(fail_actual_b), checks: int'(checks_passed_b)};
    endfunction

    task automatic check_res(input string tag, input res_t act, input res_t exp);
        check({tag, ".done_edge"}, act.kd, exp.kd);
        check({tag, ".pass"}, act.pass, exp.pass);
        check({tag, ".fail"}, act.fail, exp.fail);
        check({tag, ".timeout"}, act.timeout, exp.timeout);
        check({tag, ".fail_index"}, act.fidx, exp.fidx);
        check({tag, ".fail_actual"}, act.fact, exp.fact);
        check({tag, ".checks_passed"}, act.checks, exp.checks);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".busy"}, int'(busy_a), 0);
        check({tag, ".done"}, int'(done_a), 0);
        check({tag, ".pass"}, int'(pass_a), 0);
        check({tag, ".fail"}, int'(fail_a), 0);
        check({tag, ".timeout"}, int'(timeout_a), 0);
        check({tag, ".fail_index"}, int'(fail_index_a), 0);
        check({tag, ".fail_actual"}, int'(fail_actual_a), 0);
        check({tag, ".checks_passed"}, int'(checks_passed_a), 0);
        check({tag, ".entry_count"}, int'(entry_count_a), 0);
        check({tag, ".load_ready"}, int'(load_ready_a), 1);
    endtask

    task automatic load_basic_table();
        tab_pc[0] = 8'd7;  tab_exp[0] = 16'd6;
        tab_pc[1] = 8'd11; tab_exp[1] = 16'd1;
        tab_pc[2] = 8'd15; tab_exp[2] = 16'd15;
        load_entries(3);
    endtask

    // Checkpoint PCs at k=1,5,9 with register samples at k=3,7,11.
    task automatic basic_seq();
        clear_seq();
        pc_seq[1] = 8'd7;  reg_seq[3]  = 16'd6;
        pc_seq[5] = 8'd11; reg_seq[7]  = 16'd1;
        pc_seq[9] = 8'd15; reg_seq[11] = 16'd15;
    endtask

    fill_vec_t fill_vec [9];
    res_t      exp_r;

    initial begin
        fill_vec[0] = '{1'b1, 8'd1, 16'd101, 1'b1, 4'd1};
        fill_vec[1] = '{1'b1, 8'd2, 16'd102, 1'b1, 4'd2};
        fill_vec[2] = '{1'b1, 8'd3, 16'd103, 1'b1, 4'd3};
        fill_vec[3] = '{1'b1, 8'd4, 16'd104, 1'b1, 4'd4};
        fill_vec[4] = '{1'b1, 8'd5, 16'd105, 1'b1, 4'd5};
        fill_vec[5] = '{1'b1, 8'd6, 16'd106, 1'b1, 4'd6};
        fill_vec[6] = '{1'b1, 8'd7, 16'd107, 1'b1, 4'd7};
        fill_vec[7] = '{1'b1, 8'd8, 16'd108, 1'b1, 4'd8};
        fill_vec[8] = '{1'b1, 8'd9, 16'd109, 1'b0, 4'd8};

        reset = 1'b1; load_valid = 1'b0; load_pc = '0; load_expected = '0;
        start = 1'b0; pc_in = '0; reg_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset_values("reset");

        // All checkpoints match.
        do_reset(); load_basic_table(); basic_seq(); run();
        exp_r = '{kd: 12, pass: 1, fail: 0, timeout: 0, fidx: 0, fact: 0, checks: 3};
        check_res("allpass_a", actual_a(), exp_r);
        check_res("allpass_b", actual_b(), exp_r);
        check("allpass_a.busy_after", int'(busy_a), 0);

        // Mismatch on entry 1.
        do_reset(); load_basic_table(); basic_seq(); reg_seq[7] = 16'd2; run();
        check_res("fail1_a", actual_a(),
                  '{kd: 8, pass: 0, fail: 1, timeout: 0, fidx: 1, fact: 2, checks: 1});
        check_res("fail1_b", actual_b(),
                  '{kd: 12, pass: 0, fail: 1, timeout: 0, fidx: 1, fact: 2, checks: 2});

        // Mismatches on entries 0 and 2.
        do_reset(); load_basic_table(); basic_seq();
        reg_seq[3] = 16'd5; reg_seq[11] = 16'd9; run();
        check_res("fail02_a", actual_a(),
                  '{kd: 4, pass: 0, fail: 1, timeout: 0, fidx: 0, fact: 5, checks: 0});
        check_res("fail02_b", actual_b(),
                  '{kd: 12, pass: 0, fail: 1, timeout: 0, fidx: 0, fact: 5, checks: 1});

        // Watchdog: PC held at 0 never matches.
        do_reset(); load_basic_table();
        start = 1'b1; @(negedge clock); start = 1'b0; pc_in = 8'd0;
        for (int k = 0; k < TOUT; k++) begin
            @(negedge clock);
            check($sformatf("tout.timeout_k%0d", k), int'(timeout_a), (k == TOUT - 1) ? 1 : 0);
            check($sformatf("tout.done_k%0d", k), int'(done_a), 0);
        end
        @(negedge clock);
        check("tout.done", int'(done_a), 1);
        check("tout.pass", int'(pass_a), 0);
        check("tout.timeout_held", int'(timeout_a), 1);

        // Fill the table with 9 consecutive writes; the 9th is refused.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            load_valid = fill_vec[i].lv; load_pc = fill_vec[i].pc; load_expected = fill_vec[i].ex;
            check($sformatf("fill.load_ready_%0d", i), int'(load_ready_a), int'(fill_vec[i].exp_ready));
            @(negedge clock);
            check($sformatf("fill.entry_count_%0d", i), int'(entry_count_a), int'(fill_vec[i].exp_count));
        end
        load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tab_pc[i] = fill_vec[i].pc; tab_exp[i] = fill_vec[i].ex;
        end
        clear_seq();
        for (int i = 0; i < DEPTH; i++) begin
            pc_seq[4*i+1] = tab_pc[i]; reg_seq[4*i+3] = tab_exp[i];
        end
        pc_seq[33] = 8'd9;
        run();
        check_res("full_a", actual_a(), model(DEPTH, 1));
        check("full_a.checks_const", int'(checks_passed_a), 8);

        // Reset while in SETTLE, then an empty run.
        do_reset(); load_basic_table(); clear_seq();
        start = 1'b1; @(negedge clock); start = 1'b0;
        pc_in = 8'd0; @(negedge clock);
        pc_in = 8'd7; @(negedge clock);
        check("midrst.busy_before", int'(busy_a), 1);
        reset = 1'b1; pc_in = 8'd0; @(negedge clock);
        reset = 1'b0;
        check_reset_values("midrst");
        start = 1'b1; @(negedge clock); start = 1'b0;
        check("empty.done_early", int'(done_a), 0);
        @(negedge clock);
        check("empty.done", int'(done_a), 1);
        check("empty.pass", int'(pass_a), 1);
        check("empty.busy", int'(busy_a), 0);

        // Randomized tables and PC/register streams against the model.
        for (int t = 0; t < 40; t++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < DEPTH; i++) begin
                tab_pc[i]  = 8'($urandom_range(0, 7));
                tab_exp[i] = 16'($urandom_range(0, 3));
            end
            for (int k = 0; k < SEQ_LEN; k++) begin
                pc_seq[k]  = 8'($urandom_range(0, (t % 3 == 0) ? 40 : 9));
                reg_seq[k] = 16'($urandom_range(0, (t % 2 == 0) ? 1 : 3));
            end
            do_reset(); load_entries(n); run();
            check_res($sformatf("rnd%0d_a", t), actual_a(), model(n, 1));
            check_res($sformatf("rnd%0d_b", t), actual_b(), model(n, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
